// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: load-use stalls,
// taken-branch flushes, memory-busy freezes and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned REG_W             = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IF_ID_Rs1,
    input  logic [REG_W-1:0] IF_ID_Rs2,
    input  logic             IF_ID_UsesRs2,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rd,
    input  logic             EX_MEM_Branch,
    input  logic             mem_busy,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             ID_EX_Flush,
    output logic             Pipe_Freeze,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            bcnt_q        <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        hz = ID_EX_MemRead && (ID_EX_Rd != '0) &&
             ((ID_EX_Rd == IF_ID_Rs1) || (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        PCSrc        = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        ID_EX_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        state_d      = state_q;
        bcnt_d       = bcnt_q;

        // rst gates the controls so an async reset shows defaults without a clock edge
        if (rst) begin
            state_d = RUN;
            bcnt_d  = '0;
        end else if (mem_busy) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (EX_MEM_Branch) begin
            PCSrc       = 1'b1;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_d     = RUN;
            bcnt_d      = '0;
        end else if (state_q == STALL) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            bcnt_d       = bcnt_q - 2'd1;
            if (bcnt_q == 2'd1) begin
                state_d = RUN;
            end
        end else if (hz) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = STALL;
                bcnt_d  = STALL_RELOAD;
            end
        end

        stall_count_d = stall_count_q;
        if (!PCWrite && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end

        flush_count_d = flush_count_q;
        if (EX_MEM_Branch && !mem_busy && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    assign stall_active = (state_q == STALL);
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with LOAD_STALL_CYCLES=2 and 8-bit counters.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TB_CNT_W = 8;

    // {PCWrite,PCSrc,IF_ID_Write,IF_ID_Flush,ID_EX_Bubble,ID_EX_Flush,Pipe_Freeze,stall_active}
    localparam logic [7:0] V_DEF   = 8'b1010_0000;
    localparam logic [7:0] V_HZ    = 8'b0000_1000;
    localparam logic [7:0] V_ST    = 8'b0000_1001;
    localparam logic [7:0] V_BR    = 8'b1111_0100;
    localparam logic [7:0] V_BR_ST = 8'b1111_0101;
    localparam logic [7:0] V_FZ_ST = 8'b0000_0011;
    localparam logic [7:0] V_FZ    = 8'b0000_0010;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [4:0]          rs1 = '0, rs2 = '0, rd = '0;
    logic                uses = 1'b0, memrd = 1'b0, br = 1'b0, busy = 1'b0;
    logic                PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush;
    logic                ID_EX_Bubble, ID_EX_Flush, Pipe_Freeze, stall_active;
    logic [TB_CNT_W-1:0] stall_count, flush_count;
    logic [7:0]          obs;

    logic [7:0]          sb[$];
    logic [7:0]          e;
    logic [TB_CNT_W-1:0] exp_stall = '0, exp_flush = '0;
    int                  tests = 0, fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .LOAD_STALL_CYCLES(2),
        .CNT_W(TB_CNT_W),
        .REG_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(uses),
        .ID_EX_MemRead(memrd), .ID_EX_Rd(rd),
        .EX_MEM_Branch(br), .mem_busy(busy),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
        .ID_EX_Flush(ID_EX_Flush), .Pipe_Freeze(Pipe_Freeze),
        .stall_active(stall_active),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    assign obs = {PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush,
                  ID_EX_Bubble, ID_EX_Flush, Pipe_Freeze, stall_active};

    // Drive one cycle of stimulus and queue its expected control vector.
    task automatic apply(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic a_uses,
                         input logic a_mr, input logic [4:0] a_rd, input logic a_br,
                         input logic a_busy, input logic [7:0] a_exp);
        @(negedge clk);
        rs1 = a_rs1; rs2 = a_rs2; uses = a_uses; memrd = a_mr; rd = a_rd;
        br = a_br; busy = a_busy;
        sb.push_back(a_exp);
        if (!a_exp[7] && exp_stall != '1) exp_stall++;
        if (a_br && !a_busy && exp_flush != '1) exp_flush++;
        #2;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; rs1 = '0; rs2 = '0; uses = 0; memrd = 0; rd = '0; br = 0; busy = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (obs !== V_DEF) begin
            fails++; $display("FAIL reset_outputs: got %b exp %b", obs, V_DEF);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_stall = '0; exp_flush = '0;
        #2;
        tests++;
        if (obs !== V_DEF || stall_count !== '0 || flush_count !== '0) begin
            fails++;
            $display("FAIL reset_release: got %b/%0d/%0d exp %b/0/0", obs, stall_count, flush_count, V_DEF);
        end
    endtask

    task automatic test_load_use;
        logic [7:0] tab[3] = '{V_HZ, V_ST, V_DEF};
        for (int i = 0; i < 3; i++) begin
            apply(5'd5, 5'd0, 1'b0, i < 2, 5'd5, 1'b0, 1'b0, tab[i]);
            e = sb.pop_front(); tests++;
            if (obs !== e) begin fails++; $display("FAIL load_use c%0d: got %b exp %b", i, obs, e); end
        end
        @(posedge clk); #1;
        tests++;
        if (stall_count !== exp_stall) begin
            fails++; $display("FAIL load_use_count: got %0d exp %0d", stall_count, exp_stall);
        end
        apply(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, V_DEF);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL rd_zero: got %b exp %b", obs, e); end
    endtask

    task automatic test_rs2_gating;
        logic [7:0] tab[4] = '{V_DEF, V_HZ, V_ST, V_DEF};
        for (int i = 0; i < 4; i++) begin
            apply(5'd1, 5'd7, i != 0, i < 3, 5'd7, 1'b0, 1'b0, tab[i]);
            e = sb.pop_front(); tests++;
            if (obs !== e) begin fails++; $display("FAIL rs2_gating c%0d: got %b exp %b", i, obs, e); end
        end
        apply(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, V_HZ);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL same_reg_hz: got %b exp %b", obs, e); end
        apply(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, V_ST);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL same_reg_st: got %b exp %b", obs, e); end
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, V_DEF);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL same_reg_end: got %b exp %b", obs, e); end
    endtask

    task automatic test_branch;
        apply(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, V_BR);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL branch_over_hz: got %b exp %b", obs, e); end
        @(posedge clk); #1;
        tests++;
        if (flush_count !== exp_flush) begin
            fails++; $display("FAIL flush_count1: got %0d exp %0d", flush_count, exp_flush);
        end
        begin
            logic [7:0] tab[3] = '{V_HZ, V_BR_ST, V_DEF};
            for (int i = 0; i < 3; i++) begin
                apply(5'd4, 5'd0, 1'b0, i == 0, 5'd4, i == 1, 1'b0, tab[i]);
                e = sb.pop_front(); tests++;
                if (obs !== e) begin fails++; $display("FAIL branch_in_stall c%0d: got %b exp %b", i, obs, e); end
            end
        end
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, V_FZ);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL busy_over_branch: got %b exp %b", obs, e); end
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, V_DEF);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL branch_idle: got %b exp %b", obs, e); end
        @(posedge clk); #1;
        tests++;
        if (flush_count !== exp_flush || stall_count !== exp_stall) begin
            fails++;
            $display("FAIL branch_counts: got %0d/%0d exp %0d/%0d", flush_count, stall_count, exp_flush, exp_stall);
        end
    endtask

    task automatic test_mem_busy;
        logic [7:0] tab[6] = '{V_HZ, V_FZ_ST, V_FZ_ST, V_FZ_ST, V_ST, V_DEF};
        logic [TB_CNT_W-1:0] base;
        base = exp_stall;
        for (int i = 0; i < 6; i++) begin
            apply(5'd6, 5'd0, 1'b0, i < 5, 5'd6, 1'b0, i >= 1 && i <= 3, tab[i]);
            e = sb.pop_front(); tests++;
            if (obs !== e) begin fails++; $display("FAIL mem_busy c%0d: got %b exp %b", i, obs, e); end
        end
        @(posedge clk); #1;
        tests++;
        if (stall_count !== base + TB_CNT_W'(5)) begin
            fails++; $display("FAIL mem_busy_count: got %0d exp %0d", stall_count, base + TB_CNT_W'(5));
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] tab[5] = '{V_HZ, V_ST, V_HZ, V_ST, V_DEF};
        for (int i = 0; i < 5; i++) begin
            apply(5'd8, 5'd0, 1'b0, i < 4, 5'd8, 1'b0, 1'b0, tab[i]);
            e = sb.pop_front(); tests++;
            if (obs !== e) begin fails++; $display("FAIL back_to_back c%0d: got %b exp %b", i, obs, e); end
        end
    endtask

    task automatic test_async_reset;
        apply(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, V_HZ);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL async_pre_hz: got %b exp %b", obs, e); end
        apply(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, V_ST);
        e = sb.pop_front(); tests++;
        if (obs !== e) begin fails++; $display("FAIL async_pre_st: got %b exp %b", obs, e); end
        #1 rst = 1'b1;
        #1;
        exp_stall = '0; exp_flush = '0;
        tests++;
        if (obs !== V_DEF || stall_count !== '0 || flush_count !== '0) begin
            fails++;
            $display("FAIL async_reset: got %b/%0d/%0d exp %b/0/0", obs, stall_count, flush_count, V_DEF);
        end
        memrd = 1'b0; rd = '0; rs1 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation;
        for (int i = 0; i < (1 << TB_CNT_W) + 3; i++) begin
            apply(5'd11, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, (i % 2 == 0) ? V_HZ : V_ST);
            e = sb.pop_front(); tests++;
            if (obs !== e) begin fails++; $display("FAIL sat_pattern c%0d: got %b exp %b", i, obs, e); end
        end
        @(posedge clk); #1;
        tests++;
        if (stall_count !== '1 || exp_stall !== '1) begin
            fails++; $display("FAIL saturation: got %0d exp %0d", stall_count, (1 << TB_CNT_W) - 1);
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_rs2_gating;
        test_branch;
        test_mem_busy;
        test_back_to_back;
        test_async_reset;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
